split_bus_arbiter: RTL and testbench

- Two-master arbiter for the serial bus with split-transaction support and a bus-hold timeout.
- Grants one master at a time and captures that master's serial slave address.
- Hands the address to the address decoder via addr/addr_rdy.
- When the addressed slave signals split, the arbiter parks the master, releases the bus to the other master, and re-grants the parked master with top priority once the slave reports ready.

---
 rtl/split_bus_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_split_bus_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/split_bus_arbiter.sv
// Two-master serial bus arbiter with split-transaction parking
// and a bounded wait timeout in START, WAIT_SLV and XFER.
module split_bus_arbiter #(
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              m1_req,
    input  logic              m2_req,
    input  logic              m1_tx,
    input  logic              m2_tx,
    input  logic              slv_ready,
    input  logic              slv_responded,
    input  logic              slv_split,
    input  logic              split_done,
    output logic              m1,
    output logic              m2,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_rdy,
    output logic              split_pending,
    output logic              timeout_err
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int CW = $clog2(ADDR_W + 1);

    typedef enum logic [2:0] {
        IDLE, START, ADDR, WAIT_SLV, XFER, RESUME
    } state_t;

    state_t            state_q, state_d;
    logic              m1_q, m1_d;
    logic              m2_q, m2_d;
    logic              last_q, last_d;   // 1: master2 held the bus last
    logic              park_q, park_d;   // 1: master2 is the parked one
    logic              pend_q, pend_d;
    logic              sdl_q, sdl_d;     // split_done seen while busy
    logic              cap_q, cap_d;     // shift register just filled
    logic              rdy_q, rdy_d;
    logic              terr_q, terr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] shift_q, shift_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     timer_q, timer_d;

    logic tx;
    logic el1;
    logic el2;
    logic expired;
    logic counting;
    logic done;

    assign tx       = m2_q ? m2_tx : m1_tx;
    assign el1      = m1_req & ~(pend_q & ~park_q);
    assign el2      = m2_req & ~(pend_q & park_q);
    assign expired  = (timer_q == TW'(TIMEOUT - 1));
    assign counting = (state_q == START) || (state_q == WAIT_SLV) ||
                      (state_q == XFER);

    // Next-state and registered-output logic for the grant FSM.
    always_comb begin
        state_d = state_q;
        m1_d    = m1_q;
        m2_d    = m2_q;
        last_d  = last_q;
        park_d  = park_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        paddr_d = paddr_q;
        cnt_d   = cnt_q;
        rdy_d   = 1'b0;
        terr_d  = 1'b0;
        cap_d   = 1'b0;
        done    = 1'b0;
        sdl_d   = sdl_q | (split_done & pend_q &
                  (state_q != IDLE) & (state_q != RESUME));

        if (cap_q) begin
            addr_d = shift_q;
            rdy_d  = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (pend_q & (split_done | sdl_q)) begin
                    state_d = RESUME;
                    m1_d    = ~park_q;
                    m2_d    = park_q;
                    sdl_d   = 1'b0;
                end else if (el1 & (~el2 | last_q)) begin
                    state_d = START;
                    m1_d    = 1'b1;
                end else if (el2) begin
                    state_d = START;
                    m2_d    = 1'b1;
                end
            end
            START: begin
                if (!tx) begin
                    state_d = ADDR;
                    cnt_d   = '0;
                end else if (expired) begin
                    terr_d = 1'b1;
                end
            end
            ADDR: begin
                shift_d = (shift_q << 1) | ADDR_W'(tx);
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(ADDR_W - 1)) begin
                    state_d = WAIT_SLV;
                    cap_d   = 1'b1;
                end
            end
            WAIT_SLV: begin
                if (slv_ready) begin
                    state_d = XFER;
                end else if (expired) begin
                    terr_d = 1'b1;
                end
            end
            XFER: begin
                if (slv_responded | (slv_split & pend_q)) begin
                    done = 1'b1;
                end else if (slv_split) begin
                    park_d  = m2_q;
                    paddr_d = addr_q;
                    pend_d  = 1'b1;
                    done    = 1'b1;
                end else if (expired) begin
                    terr_d = 1'b1;
                end
            end
            RESUME: begin
                addr_d  = paddr_q;
                rdy_d   = 1'b1;
                pend_d  = 1'b0;
                state_d = WAIT_SLV;
            end
            default: state_d = IDLE;
        endcase

        if (done | terr_d) begin
            m1_d    = 1'b0;
            m2_d    = 1'b0;
            last_d  = m2_q;
            state_d = IDLE;
        end

        if ((state_d != state_q) || !counting) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            m1_q    <= 1'b0;
            m2_q    <= 1'b0;
            last_q  <= 1'b1;
            park_q  <= 1'b0;
            pend_q  <= 1'b0;
            sdl_q   <= 1'b0;
            cap_q   <= 1'b0;
            rdy_q   <= 1'b0;
            terr_q  <= 1'b0;
            addr_q  <= '0;
            shift_q <= '0;
            paddr_q <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
            last_q  <= last_d;
            park_q  <= park_d;
            pend_q  <= pend_d;
            sdl_q   <= sdl_d;
            cap_q   <= cap_d;
            rdy_q   <= rdy_d;
            terr_q  <= terr_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            paddr_q <= paddr_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
        end
    end

    assign m1            = m1_q;
    assign m2            = m2_q;
    assign addr          = addr_q;
    assign addr_rdy      = rdy_q;
    assign split_pending = pend_q;
    assign timeout_err   = terr_q;

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Bench for split_bus_arbiter: directed scenarios with literal
// expectations plus random traffic checked against a cycle-stamped model.
module tb_split_bus_arbiter;

    localparam int AW = 2;
    localparam int TO = 64;

    localparam int P_IDLE  = 0;
    localparam int P_START = 1;
    localparam int P_ADDR  = 2;
    localparam int P_WAIT  = 3;
    localparam int P_XFER  = 4;
    localparam int P_RES   = 5;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic m1_req = 1'b0;
    logic m2_req = 1'b0;
    logic m1_tx = 1'b1;
    logic m2_tx = 1'b1;
    logic slv_ready = 1'b0;
    logic slv_responded = 1'b0;
    logic slv_split = 1'b0;
    logic split_done = 1'b0;
    logic m1;
    logic m2;
    logic [AW-1:0] addr;
    logic addr_rdy;
    logic split_pending;
    logic timeout_err;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 0;

    split_bus_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rstn(rstn),
        .m1_req(m1_req),
        .m2_req(m2_req),
        .m1_tx(m1_tx),
        .m2_tx(m2_tx),
        .slv_ready(slv_ready),
        .slv_responded(slv_responded),
        .slv_split(slv_split),
        .split_done(split_done),
        .m1(m1),
        .m2(m2),
        .addr(addr),
        .addr_rdy(addr_rdy),
        .split_pending(split_pending),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int cyc, since, emit_at, acc, g, ph, last, parked, paddr, txv;
    bit sd_seen, w1, w2, timed, stop;
    logic e_m1, e_m2, e_rdy, e_pend, e_terr;
    logic [AW-1:0] e_addr, old_addr;

    initial begin : model
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                cyc = 0; since = 0; emit_at = -1; acc = 0;
                g = 0; ph = P_IDLE; last = 2; parked = 0; paddr = 0;
                sd_seen = 0;
                e_m1 = 0; e_m2 = 0; e_rdy = 0; e_pend = 0; e_terr = 0;
                e_addr = '0;
            end else begin
                cyc++;
                txv = (g == 2) ? int'(m2_tx) : int'(m1_tx);
                e_rdy = 0; e_terr = 0; stop = 0;
                old_addr = e_addr;
                timed = ((cyc - since) == TO);
                if (parked != 0 && split_done && ph != P_IDLE && ph != P_RES)
                    sd_seen = 1;
                case (ph)
                    P_IDLE: begin
                        if (parked != 0 && (split_done || sd_seen)) begin
                            g = parked; ph = P_RES; since = cyc; sd_seen = 0;
                        end else begin
                            w1 = m1_req && parked != 1;
                            w2 = m2_req && parked != 2;
                            if (w1 && w2) g = (last == 1) ? 2 : 1;
                            else if (w1) g = 1;
                            else if (w2) g = 2;
                            if (g != 0) begin ph = P_START; since = cyc; end
                        end
                    end
                    P_START: begin
                        if (txv == 0) begin ph = P_ADDR; since = cyc; acc = 0; end
                        else if (timed) begin stop = 1; e_terr = 1; end
                    end
                    P_ADDR: begin
                        acc = acc * 2 + txv;
                        if (cyc - since == AW) begin
                            ph = P_WAIT; since = cyc; emit_at = cyc + 1;
                        end
                    end
                    P_WAIT: begin
                        if (slv_ready) begin ph = P_XFER; since = cyc; end
                        else if (timed) begin stop = 1; e_terr = 1; end
                    end
                    P_XFER: begin
                        if (slv_responded || (slv_split && parked != 0)) stop = 1;
                        else if (slv_split) begin
                            parked = g; paddr = int'(old_addr); stop = 1;
                        end else if (timed) begin stop = 1; e_terr = 1; end
                    end
                    default: begin
                        e_addr = AW'(paddr); e_rdy = 1; parked = 0;
                        ph = P_WAIT; since = cyc;
                    end
                endcase
                if (stop) begin last = g; g = 0; ph = P_IDLE; since = cyc; end
                if (cyc == emit_at) begin
                    e_addr = AW'(acc); e_rdy = 1; emit_at = -1;
                end
                e_m1 = (g == 1);
                e_m2 = (g == 2);
                e_pend = (parked != 0);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_en && rstn) begin
                check("cmp_m1", int'(m1), int'(e_m1));
                check("cmp_m2", int'(m2), int'(e_m2));
                check("cmp_addr", int'(addr), int'(e_addr));
                check("cmp_addr_rdy", int'(addr_rdy), int'(e_rdy));
                check("cmp_split_pending", int'(split_pending), int'(e_pend));
                check("cmp_timeout_err", int'(timeout_err), int'(e_terr));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_in();
        m1_req = 0; m2_req = 0; m1_tx = 1; m2_tx = 1;
        slv_ready = 0; slv_responded = 0; slv_split = 0; split_done = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_in();
        rstn = 0;
        tick();
        tick();
        rstn = 1;
    endtask

    task automatic set_tx(input int m, input logic v);
        if (m == 1) m1_tx = v;
        else m2_tx = v;
    endtask

    task automatic send_addr(input int m, input logic [1:0] a);
        set_tx(m, 1'b0);
        tick();
        set_tx(m, a[1]);
        tick();
        set_tx(m, a[0]);
        tick();
        check("rdy_not_early", int'(addr_rdy), 0);
        set_tx(m, 1'b1);
        tick();
    endtask

    task automatic finish_x();
        slv_ready = 1;
        tick();
        slv_ready = 0;
        slv_responded = 1;
        tick();
        slv_responded = 0;
    endtask

    bit quiet;

    initial begin : stim
        do_reset();
        check("rst_m1", int'(m1), 0);
        check("rst_m2", int'(m2), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_rdy", int'(addr_rdy), 0);
        check("rst_pend", int'(split_pending), 0);
        check("rst_terr", int'(timeout_err), 0);
        cmp_en = 1;

        // single request
        m1_req = 1;
        tick();
        check("t1_grant_m1", int'(m1), 1);
        check("t1_no_m2", int'(m2), 0);
        send_addr(1, 2'b10);
        check("t1_rdy", int'(addr_rdy), 1);
        check("t1_addr", int'(addr), 2);
        tick();
        check("t1_rdy_pulse", int'(addr_rdy), 0);
        slv_ready = 1;
        tick();
        slv_ready = 0;
        slv_responded = 1;
        m1_req = 0;
        tick();
        slv_responded = 0;
        check("t1_drop", int'(m1), 0);

        // simultaneous requests, round robin
        do_reset();
        m1_req = 1; m2_req = 1;
        tick();
        check("t2_first_m1", int'(m1), 1);
        check("t2_first_not_m2", int'(m2), 0);
        send_addr(1, 2'b11);
        check("t2_addr1", int'(addr), 3);
        finish_x();
        check("t2_drop", int'(m1 | m2), 0);
        tick();
        check("t2_second_m2", int'(m2), 1);
        send_addr(2, 2'b01);
        check("t2_addr2", int'(addr), 1);
        finish_x();
        tick();
        check("t2_third_m1", int'(m1), 1);

        // split and resume
        do_reset();
        m1_req = 1; m2_req = 1;
        tick();
        check("t3_m1", int'(m1), 1);
        send_addr(1, 2'b00);
        check("t3_addr0", int'(addr), 0);
        slv_ready = 1;
        tick();
        slv_ready = 0;
        slv_split = 1;
        tick();
        slv_split = 0;
        check("t3_park_drop", int'(m1), 0);
        check("t3_pend", int'(split_pending), 1);
        tick();
        check("t3_m2_grant", int'(m2), 1);
        check("t3_m1_parked", int'(m1), 0);
        send_addr(2, 2'b01);
        check("t3_addr_m2", int'(addr), 1);
        slv_ready = 1;
        tick();
        slv_ready = 0;
        slv_responded = 1;
        m2_req = 0;
        tick();
        slv_responded = 0;
        check("t3_m2_drop", int'(m2), 0);
        repeat (3) tick();
        check("t3_parked_nogrant", int'(m1), 0);
        check("t3_still_pend", int'(split_pending), 1);
        split_done = 1;
        tick();
        split_done = 0;
        check("t3_resume_m1", int'(m1), 1);
        tick();
        check("t3_resume_rdy", int'(addr_rdy), 1);
        check("t3_resume_addr", int'(addr), 0);
        check("t3_resume_pend", int'(split_pending), 0);

        // timeout in WAIT_SLV
        do_reset();
        m2_req = 1;
        tick();
        check("t4_m2", int'(m2), 1);
        m2_req = 0;
        send_addr(2, 2'b10);
        repeat (TO - 2) tick();
        check("t4_no_terr_yet", int'(timeout_err), 0);
        check("t4_m2_held", int'(m2), 1);
        tick();
        check("t4_terr", int'(timeout_err), 1);
        check("t4_m2_drop", int'(m2), 0);
        tick();
        check("t4_terr_pulse", int'(timeout_err), 0);

        // async reset during XFER with a parked master
        do_reset();
        m1_req = 1;
        tick();
        send_addr(1, 2'b01);
        slv_ready = 1;
        tick();
        slv_ready = 0;
        slv_split = 1;
        m1_req = 0;
        m2_req = 1;
        tick();
        slv_split = 0;
        tick();
        check("t5_m2", int'(m2), 1);
        send_addr(2, 2'b11);
        slv_ready = 1;
        tick();
        slv_ready = 0;
        check("t5_pend_before", int'(split_pending), 1);
        check("t5_addr_before", int'(addr), 3);
        #2 rstn = 0;
        #1;
        check("t5_async_m2", int'(m2), 0);
        check("t5_async_addr", int'(addr), 0);
        check("t5_async_pend", int'(split_pending), 0);

        // random traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) m1_req = ~m1_req;
            if ($urandom_range(0, 9) == 0) m2_req = ~m2_req;
            m1_tx = ($urandom_range(0, 3) != 0);
            m2_tx = ($urandom_range(0, 3) != 0);
            quiet = (i % 400) >= 300;
            slv_ready = !quiet && ($urandom_range(0, 4) == 0);
            slv_responded = !quiet && ($urandom_range(0, 9) == 0);
            slv_split = !quiet && ($urandom_range(0, 11) == 0);
            split_done = ($urandom_range(0, 14) == 0);
            if (i == 2000) rstn = 0;
            if (i == 2002) rstn = 1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
